// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad synchroniser/debouncer, BCD operand entry and LCD echo sequencer.
module key_entry_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int MAX_DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             i_sw_push,
    output logic [4*MAX_DIGITS-1:0] o_bcd,
    output logic [2:0]              o_digit_cnt,
    output logic                    o_valid,
    output logic                    o_clr,
    output logic                    o_ovf,
    output logic [7:0]              o_lcd_data,
    output logic                    o_lcd_wr,
    input  logic                    i_lcd_rdy
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    typedef enum logic [2:0] {IDLE, DEBOUNCE, ACT, LCD_WR, WAIT_REL} state_t;
    state_t      state;
    logic [11:0] sync1, key, code;
    logic [CW-1:0] cnt;
    logic [3:0]  digit;
    // Digit 0 sits on bit 11, digit 9 on bit 2.
    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) if (code[11-i]) digit = 4'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            key         <= '0;
            code        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            o_bcd       <= '0;
            o_digit_cnt <= '0;
            o_valid     <= 1'b0;
            o_clr       <= 1'b0;
            o_ovf       <= 1'b0;
            o_lcd_data  <= 8'h20;
            o_lcd_wr    <= 1'b0;
        end else begin
            sync1   <= i_sw_push;
            key     <= sync1;
            o_valid <= 1'b0;
            o_clr   <= 1'b0;
            o_ovf   <= 1'b0;
            case (state)
                IDLE: if ($onehot(key)) begin
                    code  <= key;
                    cnt   <= '0;
                    state <= DEBOUNCE;
                end
                DEBOUNCE: if (key != code) state <= IDLE;
                else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DEBOUNCE_CYC - 2)) state <= ACT;
                end
                ACT: begin
                    cnt   <= '0;
                    state <= WAIT_REL;
                    if (code[1]) o_clr <= 1'b1;
                    else if (code[0]) o_valid <= o_digit_cnt != 3'd0;
                    else if (o_digit_cnt < 3'(MAX_DIGITS)) begin
                        o_bcd       <= {o_bcd[4*MAX_DIGITS-5:0], digit};
                        o_digit_cnt <= o_digit_cnt + 3'd1;
                        o_lcd_data  <= 8'h30 + 8'(digit);
                        state       <= LCD_WR;
                    end else o_ovf <= 1'b1;
                end
                LCD_WR: if (!o_lcd_wr) o_lcd_wr <= 1'b1;
                else if (i_lcd_rdy) begin
                    o_lcd_wr <= 1'b0;
                    state    <= WAIT_REL;
                end
                WAIT_REL: begin
                    // Operand is cleared the cycle after the clear/enter pulse so o_valid sees it intact.
                    if (o_valid || o_clr) begin
                        o_bcd       <= '0;
                        o_digit_cnt <= '0;
                    end
                    if (key != '0) cnt <= '0;
                    else if (cnt == CW'(DEBOUNCE_CYC - 1)) state <= IDLE;
                    else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
